// File: rtl/multi_dataflow_job_sched.sv
// Round-robin job scheduler sharing one multi_dataflow HWPE between N_CORES cores,
// with a per-job watchdog that aborts and clears the accelerator on timeout.
module multi_dataflow_job_sched #(
  parameter int N_CORES   = 2,
  parameter int TIMEOUT_W = 16,
  parameter int OWNER_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_CORES-1:0]   req_i,
  output logic [N_CORES-1:0]   gnt_o,
  output logic [OWNER_W-1:0]   owner_o,
  output logic                 busy_o,
  output logic                 trigger_o,
  input  logic                 done_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic [N_CORES-1:0]   evt_o,
  output logic [N_CORES-1:0]   err_o,
  output logic                 clear_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [OWNER_W-1:0]   LAST_INIT = OWNER_W'(N_CORES - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX   = {TIMEOUT_W{1'b1}};

  state_t               state_q;
  logic [OWNER_W-1:0]   owner_q;
  logic [OWNER_W-1:0]   last_owner_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [N_CORES-1:0]   gnt_q;
  logic [N_CORES-1:0]   evt_q;
  logic [N_CORES-1:0]   err_q;
  logic                 busy_q;
  logic                 trigger_q;
  logic                 clear_q;

  logic                 win_valid_s;
  logic [OWNER_W-1:0]   win_idx_s;
  logic [OWNER_W-1:0]   cand_s;

  function automatic logic [N_CORES-1:0] onehot(input logic [OWNER_W-1:0] idx);
    logic [N_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin winner: first requester after the last owner, with wrap.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= N_CORES; i++) begin
      cand_s = OWNER_W'((int'(last_owner_q) + i) % N_CORES);
      if (!win_valid_s && req_i[cand_s]) begin
        win_valid_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Scheduler FSM; pulse outputs are registered alongside the state they decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_INIT;
      cnt_q        <= '0;
      limit_q      <= '0;
      gnt_q        <= '0;
      evt_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      trigger_q    <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      gnt_q     <= '0;
      evt_q     <= '0;
      err_q     <= '0;
      trigger_q <= 1'b0;
      clear_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid_s) begin
            owner_q      <= win_idx_s;
            last_owner_q <= win_idx_s;
            gnt_q        <= onehot(win_idx_s);
            busy_q       <= 1'b1;
            state_q      <= ST_GRANT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          limit_q   <= timeout_i;
          trigger_q <= 1'b1;
          state_q   <= ST_START;
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // done has priority over a watchdog expiry in the same cycle
          if (done_i) begin
            evt_q   <= onehot(owner_q);
            state_q <= ST_DONE;
          end else if ((limit_q != '0) && (cnt_q == (limit_q - TIMEOUT_W'(1)))) begin
            err_q   <= onehot(owner_q);
            clear_q <= 1'b1;
            state_q <= ST_ABORT;
          end else begin
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + TIMEOUT_W'(1);
            end else begin
              cnt_q <= cnt_q;
            end
            state_q <= ST_RUN;
          end
        end
        ST_DONE, ST_ABORT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign owner_o   = owner_q;
  assign busy_o    = busy_q;
  assign trigger_o = trigger_q;
  assign evt_o     = evt_q;
  assign err_o     = err_q;
  assign clear_o   = clear_q;

endmodule

// File: tb/tb_multi_dataflow_job_sched.sv
// Scoreboard bench: stimulus pushes expected output events with their cycle numbers,
// a monitor pops one entry each time the DUT pulses an output or changes busy_o.
module tb_multi_dataflow_job_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic        done;
  logic [15:0] timeout;
  logic [1:0]  gnt;
  logic [0:0]  owner;
  logic        busy;
  logic        trig;
  logic [1:0]  evt;
  logic [1:0]  err;
  logic        clr;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    int         c;
    logic [1:0] g;
    logic       t;
    logic [1:0] e;
    logic [1:0] er;
    logic       cl;
    logic       b;
    logic       o;
  } rec_t;

  rec_t exp_q[$];

  multi_dataflow_job_sched #(.N_CORES(2), .TIMEOUT_W(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .owner_o  (owner),
    .busy_o   (busy),
    .trigger_o(trig),
    .done_i   (done),
    .timeout_i(timeout),
    .evt_o    (evt),
    .err_o    (err),
    .clear_o  (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string nm, input int c, input logic [1:0] g, input logic t,
                      input logic [1:0] e, input logic [1:0] er, input logic cl,
                      input logic b, input logic o);
    rec_t r;
    r.nm = nm; r.c = c; r.g = g; r.t = t; r.e = e; r.er = er; r.cl = cl; r.b = b; r.o = o;
    exp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  // Monitor: any pulse or busy edge is one observed event, checked against the queue head.
  initial begin : monitor
    logic busy_prev;
    rec_t r;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (gnt != 2'b00 || evt != 2'b00 || err != 2'b00 || trig || clr || busy !== busy_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: cyc=%0d gnt=%b trig=%b evt=%b err=%b clr=%b busy=%b own=%0d, required no event",
                   cyc, gnt, trig, evt, err, clr, busy, owner);
        end else begin
          r = exp_q.pop_front();
          if (cyc !== r.c || gnt !== r.g || trig !== r.t || evt !== r.e || err !== r.er ||
              clr !== r.cl || busy !== r.b || owner[0] !== r.o) begin
            errors++;
            $display("FAIL %s: got cyc=%0d gnt=%b trig=%b evt=%b err=%b clr=%b busy=%b own=%0d, required cyc=%0d gnt=%b trig=%b evt=%b err=%b clr=%b busy=%b own=%0d",
                     r.nm, cyc, gnt, trig, evt, err, clr, busy, owner,
                     r.c, r.g, r.t, r.e, r.er, r.cl, r.b, r.o);
          end
        end
      end
      busy_prev = busy;
    end
  end

  initial begin : stim
    int t;
    int t0;
    int base;
    int o;
    int u;
    rst = 1'b1; req = 2'b00; done = 1'b0; timeout = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, evt, err, owner, busy, trig, clr} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b evt=%b err=%b own=%b busy=%b trig=%b clr=%b, required all 0",
               gnt, evt, err, owner, busy, trig, clr);
    end
    step();
    rst = 1'b0;

    // Single job, done in the 4th RUN cycle.
    step(); t = cyc; req = 2'b01; timeout = 16'd0;
    push("t1_gnt",  t+1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push("t1_trig", t+2, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push("t1_evt",  t+7, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    push("t1_idle", t+8, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_cyc(t+1); req = 2'b00;
    wait_cyc(t+6); done = 1'b1; step(); done = 1'b0;
    wait_cyc(t+10);

    // Round-robin with immediate re-requests; reset first so core 0 leads.
    rst = 1'b1; step(); rst = 1'b0;
    step(); t0 = cyc; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      base = t0 + 5*k;
      o    = k % 2;
      push("rr_gnt",  base+1, (o == 0) ? 2'b01 : 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o[0]);
      push("rr_trig", base+2, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, o[0]);
      push("rr_evt",  base+4, 2'b00, 1'b0, (o == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0, 1'b1, o[0]);
      push("rr_idle", base+5, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, o[0]);
      wait_cyc(base+1);
      req[o] = 1'b0;
      if (k == 3) req = 2'b00;
      wait_cyc(base+2);
      if (k < 3) req[o] = 1'b1;
      wait_cyc(base+3); done = 1'b1; step(); done = 1'b0;
    end
    wait_cyc(t0+22);

    // Watchdog: limit 8, no done.
    timeout = 16'd8;
    step(); t = cyc; req = 2'b10;
    push("wd_gnt",  t+1,  2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push("wd_trig", t+2,  2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push("wd_err",  t+11, 2'b00, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1);
    push("wd_idle", t+12, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_cyc(t+1); req = 2'b00;
    wait_cyc(t+14);

    // done and watchdog expiry in the same RUN cycle: done wins.
    timeout = 16'd3;
    step(); t = cyc; req = 2'b01;
    push("sim_gnt",  t+1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push("sim_trig", t+2, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push("sim_evt",  t+6, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    push("sim_idle", t+7, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_cyc(t+1); req = 2'b00;
    wait_cyc(t+5); done = 1'b1; step(); done = 1'b0;
    wait_cyc(t+9);

    // Stray done in IDLE, then a limit of 5 changed to 0 mid-job.
    step(); done = 1'b1; step(); done = 1'b0; step();
    timeout = 16'd5; t = cyc; req = 2'b10;
    push("lat_gnt",  t+1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push("lat_trig", t+2, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push("lat_err",  t+8, 2'b00, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1);
    push("lat_idle", t+9, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_cyc(t+1); req = 2'b00;
    wait_cyc(t+4); timeout = 16'd0;
    wait_cyc(t+11);

    // Reset during RUN with owner 1, then both cores request.
    step(); t = cyc; req = 2'b10;
    push("rm_gnt",   t+1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push("rm_trig",  t+2, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push("rm_reset", t+5, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_cyc(t+1); req = 2'b00;
    wait_cyc(t+5); rst = 1'b1; req = 2'b11;
    step(); step(); rst = 1'b0; u = cyc;
    push("rm_gnt0",  u+1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push("rm_trig0", u+2, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push("rm_evt0",  u+4, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    push("rm_idle0", u+5, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_cyc(u+1); req = 2'b00;
    wait_cyc(u+3); done = 1'b1; step(); done = 1'b0;
    wait_cyc(u+10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unobserved entries (first %s at cyc %0d), required 0",
               exp_q.size(), exp_q[0].nm, exp_q[0].c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
